sram_arbiter: RTL and testbench

//  Shared-SRAM access controller: arbitrates NCH request channels (IF fetch, MEM load/store, debug/UART)

---
 rtl/sram_arbiter_pkg.sv | 15 +
 rtl/sram_arb_pick.sv | 42 ++++
 rtl/sram_arbiter.sv | 113 +++++++++++
 tb/tb_sram_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: FSM state encodings, channel ids and index-width helper shared by the SRAM arbiter files
package sram_arbiter_pkg;
  localparam logic [2:0] SA_IDLE     = 3'd0;
  localparam logic [2:0] SA_RD_ACC   = 3'd1;
  localparam logic [2:0] SA_RD_DONE  = 3'd2;
  localparam logic [2:0] SA_WR_SETUP = 3'd3;
  localparam logic [2:0] SA_WR_PULSE = 3'd4;
  localparam logic [2:0] SA_WR_DONE  = 3'd5;
  localparam int CH_IF  = 0;
  localparam int CH_MEM = 1;
  localparam int CH_DBG = 2;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational winner select; ports i_req/i_ptr -> o_gnt (one-hot), o_idx, o_any; round-robin when SRAM_ARB_RR_EN is defined
module sram_arb_pick
  import sram_arbiter_pkg::*;
#(
  parameter int NCH = 3,
  localparam int IW = idx_w(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt,
  output logic [IW-1:0]  o_idx,
  output logic           o_any
);
  assign o_any = |i_req;
`ifdef SRAM_ARB_RR_EN
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NCH]) begin
        o_gnt = '0;
        o_gnt[(int'(i_ptr) + k) % NCH] = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % NCH);
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_gnt = '0;
        o_gnt[k] = 1'b1;
        o_idx = IW'(k);
      end
    end
  end
`endif
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates NCH channels onto one async SRAM bank via a multi-cycle access FSM (SRAM_ARB_RR_EN selects round-robin)
// ports: i_clk, i_rst_n (async active-low), i_req/i_wr/i_addr/i_wdata per channel; o_gnt one-hot done pulse, o_rdata, o_busy;
//        o_sram_addr, io_sram_data (driven only in write states), o_sram_oe/o_sram_we/o_sram_en active-low
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH-1:0]    i_wr,
  input  logic [NCH*AW-1:0] i_addr,
  input  logic [NCH*DW-1:0] i_wdata,
  output logic [NCH-1:0]    o_gnt,
  output logic [DW-1:0]     o_rdata,
  output logic [NCH-1:0]    o_busy,
  output logic [AW-1:0]     o_sram_addr,
  inout  wire  [DW-1:0]     io_sram_data,
  output logic              o_sram_oe,
  output logic              o_sram_we,
  output logic              o_sram_en
);
  localparam int IW = idx_w(NCH);
  logic [2:0]     r_state;
  logic [2:0]     r_cnt;
  logic [NCH-1:0] r_oh;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [DW-1:0]  r_rdata;
  logic [IW-1:0]  w_ptr;
  logic [IW-1:0]  w_idx;
  logic [NCH-1:0] w_oh;
  logic           w_any;
  logic           w_rd_last;
  logic           w_wr_last;
  logic           w_drive;
`ifdef SRAM_ARB_RR_EN
  logic [IW-1:0]  r_ptr;
  logic [IW-1:0]  r_id;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif
  sram_arb_pick #(.NCH(NCH)) u_pick (
    .i_req (i_req),
    .i_ptr (w_ptr),
    .o_gnt (w_oh),
    .o_idx (w_idx),
    .o_any (w_any)
  );
  assign w_rd_last = r_cnt == 3'(RD_WAIT);
  assign w_wr_last = r_cnt == 3'(WR_WAIT);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SA_IDLE;
      r_cnt   <= '0;
      r_oh    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef SRAM_ARB_RR_EN
      r_ptr   <= '0;
      r_id    <= '0;
`endif
    end else begin
      case (r_state)
        SA_IDLE: if (w_any) begin
          r_oh    <= w_oh;
          r_addr  <= i_addr[w_idx*AW +: AW];
          r_wdata <= i_wdata[w_idx*DW +: DW];
          r_cnt   <= '0;
          r_state <= i_wr[w_idx] ? SA_WR_SETUP : SA_RD_ACC;
`ifdef SRAM_ARB_RR_EN
          r_id    <= w_idx;
`endif
        end
        SA_RD_ACC: begin
          r_cnt <= w_rd_last ? r_cnt : r_cnt + 3'd1;
          if (w_rd_last) begin
            r_rdata <= io_sram_data;
            r_state <= SA_RD_DONE;
          end
        end
        SA_WR_SETUP: r_state <= SA_WR_PULSE;
        SA_WR_PULSE: begin
          r_cnt   <= w_wr_last ? r_cnt : r_cnt + 3'd1;
          r_state <= w_wr_last ? SA_WR_DONE : SA_WR_PULSE;
        end
        SA_RD_DONE, SA_WR_DONE: begin
          r_state <= SA_IDLE;
`ifdef SRAM_ARB_RR_EN
          r_ptr   <= (r_id == IW'(NCH - 1)) ? '0 : r_id + 1'b1;
`endif
        end
        default: r_state <= SA_IDLE;
      endcase
    end
  end
  assign w_drive      = r_state == SA_WR_SETUP || r_state == SA_WR_PULSE || r_state == SA_WR_DONE;
  assign io_sram_data = w_drive ? r_wdata : 'z;
  assign o_gnt        = (r_state == SA_RD_DONE || r_state == SA_WR_DONE) ? r_oh : '0;
  assign o_busy       = i_req & ~o_gnt;
  assign o_rdata      = r_rdata;
  assign o_sram_addr  = r_addr;
  assign o_sram_oe    = r_state != SA_RD_ACC;
  assign o_sram_we    = r_state != SA_WR_PULSE;
  assign o_sram_en    = r_state == SA_IDLE;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter with an async SRAM model and protocol checker
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  wr = '0;
  logic [53:0] addr = '0;
  logic [47:0] wdata = '0;
  logic [2:0]  gnt;
  logic [2:0]  busy;
  logic [15:0] rdata;
  logic [17:0] saddr;
  wire  [15:0] sdata;
  logic        oe, we, en;
  logic [15:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [15:0] pre_d = '0;
  logic [2:0]  seen;
  logic [2:0]  prev_g = '0;
  logic [2:0]  g;
  logic [15:0] dlog [0:31];
  int          checks = 0;
  int          errors = 0;
  int          lat, n_oe, n_we;
  sram_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_wr         (wr),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_gnt        (gnt),
    .o_rdata      (rdata),
    .o_busy       (busy),
    .o_sram_addr  (saddr),
    .io_sram_data (sdata),
    .o_sram_oe    (oe),
    .o_sram_we    (we),
    .o_sram_en    (en)
  );
  always #5 clk = ~clk;
  assign sdata = (!oe && !en) ? mem[saddr[7:0]] : 'z;
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (rst_n && !we && !en) mem[saddr[7:0]] <= sdata;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen <= '0;
    else seen <= (seen | req) & ~gnt;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((!oe && !we) || ((!oe || !we) && en) || (gnt & ~seen) != 0 || $countones(gnt) > 1 || (gnt & prev_g) != 0) begin
        errors++;
        $display("FAIL protocol t=%0t oe=%b we=%b en=%b gnt=%b prev_gnt=%b seen=%b", $time, oe, we, en, gnt, prev_g, seen);
      end
    end
    prev_g = gnt;
  end
  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask
  task automatic set_ch(input int ch, input logic w, input logic [17:0] a, input logic [15:0] d);
    addr[ch*18 +: 18] = a;
    wdata[ch*16 +: 16] = d;
    wr[ch] = w;
    req[ch] = 1'b1;
  endtask
  task automatic wait_gnt();
    lat = 0; n_oe = 0; n_we = 0; g = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      dlog[lat] = sdata;
      if (!oe) n_oe++;
      if (!we) n_we++;
      if (gnt != 0) begin
        g = gnt;
        break;
      end
    end
    if (g == 0) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: no gnt within %0d cycles", lat);
    end
  endtask
  task automatic test_reset();
    req = 3'b011;
    repeat (2) @(negedge clk);
    checks++;
    if ({oe, we, en} !== 3'b111 || gnt !== 3'b000 || rdata !== 16'h0 || saddr !== 18'h0 || busy !== 3'b011) begin
      errors++;
      $display("FAIL reset: oe/we/en=%b gnt=%b rdata=%h addr=%h busy=%b, want 111 000 0000 00000 011", {oe, we, en}, gnt, rdata, saddr, busy);
    end
    req = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_contention();
    logic [2:0] exp;
    preload(8'h20, 16'hA000);
    preload(8'h21, 16'hA001);
    preload(8'h22, 16'hA002);
    for (int c = 0; c < 3; c++) set_ch(c, 1'b0, 18'h20 + 18'(c), 16'h0);
    for (int n = 0; n < 6; n++) begin
`ifdef SRAM_ARB_RR_EN
      exp = 3'b001 << (n % 3);
`else
      exp = 3'b001;
`endif
      wait_gnt();
      if (n == 5) req = '0;
      checks++;
      if (g !== exp || rdata !== 16'hA000 + 16'($clog2(exp))) begin
        errors++;
        $display("FAIL contention[%0d]: gnt=%b rdata=%h, want %b %h", n, g, rdata, exp, 16'hA000 + 16'($clog2(exp)));
      end
    end
    @(negedge clk);
  endtask
  task automatic test_single_read();
    preload(8'h10, 16'h1234);
    set_ch(1, 1'b0, 18'h00010, 16'h0);
    wait_gnt();
    checks++;
    if (lat != 3 || g !== 3'b010 || n_oe != 2 || n_we != 0 || rdata !== 16'h1234 || busy !== 3'b000) begin
      errors++;
      $display("FAIL single_read: lat=%0d gnt=%b oe_low=%0d we_low=%0d rdata=%h busy=%b, want 3 010 2 0 1234 000", lat, g, n_oe, n_we, rdata, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || rdata !== 16'h1234 || en !== 1'b1) begin
      errors++;
      $display("FAIL read_hold: gnt=%b rdata=%h en=%b, want 000 1234 1", gnt, rdata, en);
    end
  endtask
  task automatic test_single_write();
    int bad;
    set_ch(0, 1'b1, 18'h00005, 16'hBEEF);
    wait_gnt();
    bad = 0;
    for (int i = 1; i <= 4; i++) if (dlog[i] !== 16'hBEEF) bad++;
    checks++;
    if (lat != 4 || g !== 3'b001 || n_we != 2 || n_oe != 0 || bad != 0 || saddr !== 18'h5) begin
      errors++;
      $display("FAIL single_write: lat=%0d gnt=%b we_low=%0d oe_low=%0d bad_data=%0d addr=%h, want 4 001 2 0 0 00005", lat, g, n_we, n_oe, bad, saddr);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (mem[5] !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_mem: mem[5]=%h, want beef", mem[5]);
    end
  endtask
  task automatic test_addr_change();
    preload(8'h30, 16'hAAAA);
    preload(8'h31, 16'h5555);
    set_ch(1, 1'b0, 18'h30, 16'h0);
    @(negedge clk);
    addr[18 +: 18] = 18'h31;
    @(negedge clk);
    checks++;
    if (saddr !== 18'h30 || oe !== 1'b0) begin
      errors++;
      $display("FAIL addr_latched: addr=%h oe=%b, want 00030 0", saddr, oe);
    end
    req[1] = 1'b0;
    wait_gnt();
    checks++;
    if (lat != 1 || g !== 3'b010 || rdata !== 16'hAAAA) begin
      errors++;
      $display("FAIL addr_change: lat=%0d gnt=%b rdata=%h, want 1 010 aaaa", lat, g, rdata);
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b1 || gnt !== 3'b000) begin
      errors++;
      $display("FAIL drop_req_idle: en=%b gnt=%b, want 1 000", en, gnt);
    end
  endtask
  task automatic test_back_to_back();
    set_ch(2, 1'b1, 18'h50, 16'hC0DE);
    wait_gnt();
    checks++;
    if (lat != 4 || g !== 3'b100) begin
      errors++;
      $display("FAIL b2b_write: lat=%0d gnt=%b, want 4 100", lat, g);
    end
    wr[2] = 1'b0;
    wait_gnt();
    req = '0;
    checks++;
    if (lat != 4 || g !== 3'b100 || rdata !== 16'hC0DE) begin
      errors++;
      $display("FAIL b2b_read: lat=%0d gnt=%b rdata=%h, want 4 100 c0de", lat, g, rdata);
    end
    @(negedge clk);
  endtask
  task automatic test_reset_mid_write();
    int gcount;
    preload(8'h40, 16'h1111);
    set_ch(2, 1'b1, 18'h40, 16'h0777);
    repeat (2) @(negedge clk);
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse: we=%b, want 0", we);
    end
    rst_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if ({oe, we, en} !== 3'b111 || gnt !== 3'b000 || saddr !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid_write: oe/we/en=%b gnt=%b addr=%h, want 111 000 00000", {oe, we, en}, gnt, saddr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (gnt != 0) gcount++;
    end
    checks++;
    if (gcount != 0 || mem[8'h40] !== 16'h1111) begin
      errors++;
      $display("FAIL aborted_write: stray_gnts=%0d mem[40]=%h, want 0 1111", gcount, mem[8'h40]);
    end
    set_ch(2, 1'b0, 18'h40, 16'h0);
    wait_gnt();
    req = '0;
    checks++;
    if (lat != 3 || g !== 3'b100 || rdata !== 16'h1111) begin
      errors++;
      $display("FAIL after_reset_read: lat=%0d gnt=%b rdata=%h, want 3 100 1111", lat, g, rdata);
    end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_single_write();
    test_addr_change();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
